// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract family: the serial controller state
// encoding, the adder slice width and the operand width legality check.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SLICE_W = 4;

   // Operands must split into whole slices and span at least two of them.
   function automatic bit width_ok(input int w);
      return (w >= 2 * SLICE_W) && ((w % SLICE_W) == 0);
   endfunction

endpackage

// File: rtl/addsub_nibble_slice.sv
// Combinational 4-bit adder with carry in/out, pin-compatible with a 74AC283
// cell so it can be replaced by the library cell at technology mapping.
module addsub_nibble_slice
   import addsub_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               ci_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               co_o
);

   logic [SLICE_W:0] sum_full;

   assign sum_full    = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, ci_i};
   assign s_o         = sum_full[SLICE_W-1:0];
   assign co_o        = sum_full[SLICE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit add/subtract: one 4-bit slice is reused for WIDTH/4 cycles,
// least significant nibble first, with the carry (or inverted borrow) held in
// a register between nibbles. Subtraction is A + ~B + 1.
module nibble_serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] y_o,
   output logic             co_o,
   output logic             v_o
);

   localparam int NIBBLES = WIDTH / SLICE_W;
   localparam int CNT_W   = $clog2(NIBBLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q, y_q;
   logic [WIDTH-1:0] a_sh_d, b_sh_d, r_sh_d;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, co_q, v_q, out_valid_q;
   logic             v_d;
   logic [SLICE_W-1:0] slice_s;
   logic             slice_co;

   addsub_nibble_slice u_slice (
      .a_i  (a_sh_q[SLICE_W-1:0]),
      .b_i  (b_sh_q[SLICE_W-1:0]),
      .ci_i (carry_q),
      .s_o  (slice_s),
      .co_o (slice_co)
   );

   // Operand shifters move toward the slice; results enter from the top so the
   // final nibble lands in the most significant position.
   assign a_sh_d = {{SLICE_W{1'b0}}, a_sh_q[WIDTH-1:SLICE_W]};
   assign b_sh_d = {{SLICE_W{1'b0}}, b_sh_q[WIDTH-1:SLICE_W]};
   assign r_sh_d = {slice_s, r_sh_q[WIDTH-1:SLICE_W]};

   // Overflow: operand signs agree (B already inverted for subtract) but the
   // result sign differs. Only meaningful on the top nibble.
   assign v_d = ~(a_sh_q[SLICE_W-1] ^ b_sh_q[SLICE_W-1]) & (slice_s[SLICE_W-1] ^ a_sh_q[SLICE_W-1]);

   // Control FSM and datapath registers; every output is registered.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         r_sh_q      <= '0;
         y_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         co_q        <= 1'b0;
         v_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_sh_q  <= a_i;
                  b_sh_q  <= b_i ^ {WIDTH{sub_i}};
                  carry_q <= sub_i;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_sh_q  <= a_sh_d;
               b_sh_q  <= b_sh_d;
               r_sh_q  <= r_sh_d;
               carry_q <= slice_co;
               if (cnt_q == CNT_LAST) begin
                  // Exit wins over the increment so the counter never wraps.
                  cnt_q       <= '0;
                  y_q         <= r_sh_d;
                  co_q        <= slice_co;
                  v_q         <= v_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // Ready depends only on state and reset, never on in_valid_i.
   assign in_ready_o  = (state_q == IDLE) && !arst_i;
   assign out_valid_o = out_valid_q;
   assign y_o         = y_q;
   assign co_o        = co_q;
   assign v_o         = v_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub (WIDTH=16): vector table, then
// backpressure, mid-operation reset and streaming sequences.
module tb_nibble_serial_addsub;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a_r = '0;
   logic [15:0] b_r = '0;
   logic        sub_r = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] y;
   logic        co;
   logic        v;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_addsub #(.WIDTH(16)) dut (
      .clk_i       (clk),
      .arst_i      (arst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a_r),
      .b_i         (b_r),
      .sub_i       (sub_r),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .y_o         (y),
      .co_o        (co),
      .v_o         (v)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] y;
      logic        co;
      logic        v;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic plus signed-range overflow rule.
   task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic s,
                            output logic [15:0] ey, output logic eco, output logic ev);
      logic [16:0] full;
      if (s) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
      else   full = {1'b0, a} + {1'b0, b};
      ey  = full[15:0];
      eco = full[16];
      if (s) ev = (a[15] != b[15]) && (ey[15] != a[15]);
      else   ev = (a[15] == b[15]) && (ey[15] != a[15]);
   endtask

   // Full transaction: accept, latency check, result check, output handshake.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] ey, input logic eco, input logic ev, input string tag);
      int lat;
      @(negedge clk);
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      a_r = a; b_r = b; sub_r = s; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " y"}, 32'(y), 32'(ey));
      chk({tag, " co"}, 32'(co), 32'(eco));
      chk({tag, " v"}, 32'(v), 32'(ev));
      chk({tag, " in_ready done"}, 32'(in_ready), 32'd0);
      $display("txn %s: a=%h b=%h sub=%0d -> y=%h co=%0d v=%0d lat=%0d", tag, a, b, s, y, co, v, lat);
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " y retained"}, 32'(y), 32'(ey));
   endtask

   initial begin
      logic [15:0] ey, y_hold;
      logic        eco, ev, co_hold, v_hold;
      int          k, last_cyc;
      logic [15:0] ra, rb;
      logic        rs;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};

      // Reset state.
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst y", 32'(y), 32'd0);
      chk("rst co", 32'(co), 32'd0);
      chk("rst v", 32'(v), 32'd0);
      @(negedge clk) arst = 1'b0;
      #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

      // Table vectors.
      for (int i = 0; i < 9; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].y, vecs[i].co, vecs[i].v,
                $sformatf("vec%0d", i));

      // Backpressure: hold in DONE with IN_VALID high and changing operands.
      @(negedge clk);
      a_r = 16'h1234; b_r = 16'h0FFF; sub_r = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("bp latency", 32'(k), 32'd4);
      y_hold = y; co_hold = co; v_hold = v;
      chk("bp y", 32'(y), 32'h2233);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a_r = 16'(16'h1111 * (c + 1)); b_r = 16'(16'h0101 * (c + 3)); sub_r = c[0];
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d y", c), 32'(y), 32'(y_hold));
         chk($sformatf("bp%0d co", c), 32'(co), 32'(co_hold));
         chk($sformatf("bp%0d v", c), 32'(v), 32'(v_hold));
         chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      end
      $display("txn bp: held y=%h co=%0d v=%0d for 5 cycles", y, co, v);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("bp release out_valid", 32'(out_valid), 32'd0);
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      run_op(16'h4321, 16'h1111, 1'b1, 16'h3210, 1'b1, 1'b0, "post-bp");

      // Reset in the middle of RUN (counter at 2).
      @(negedge clk);
      a_r = 16'hFFFF; b_r = 16'h0001; sub_r = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 arst = 1'b1;
      #1;
      chk("midrst y", 32'(y), 32'd0);
      chk("midrst co", 32'(co), 32'd0);
      chk("midrst v", 32'(v), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd0);
      $display("txn midrst: aborted op a=ffff b=0001 sub=1");
      @(negedge clk) arst = 1'b0;
      run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after-rst");

      // Streaming with both handshakes tied high.
      void'($urandom(32'd1234));
      out_ready = 1'b1;
      @(negedge clk);
      last_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(1, 0));
         if (i == 0) begin ra = 16'h7FFF; rb = 16'h7FFF; rs = 1'b0; end
         if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; rs = 1'b1; end
         ref_model(ra, rb, rs, ey, eco, ev);
         a_r = ra; b_r = rb; sub_r = rs; in_valid = 1'b1;
         k = 0;
         while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk($sformatf("stream%0d y", i), 32'(y), 32'(ey));
         chk($sformatf("stream%0d co", i), 32'(co), 32'(eco));
         chk($sformatf("stream%0d v", i), 32'(v), 32'(ev));
         if (i > 0) chk($sformatf("stream%0d interval", i), 32'(cyc - last_cyc), 32'd6);
         $display("txn stream%0d: a=%h b=%h sub=%0d -> y=%h co=%0d v=%0d at cycle %0d",
                  i, ra, rb, rs, y, co, v, cyc);
         last_cyc = cyc;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
